// File: rtl/rx_timer_ctrl.sv
// Bit-period sequencer for the serial receiver: drives a 4-bit flex counter through start-midpoint, data, stop.
// Optional PARITY_EN inserts an even-parity bit check between the data bits and the stop bit.
module rx_timer_ctrl #(
   parameter int unsigned BIT_PERIOD  = 10,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned HALF_PERIOD = BIT_PERIOD / 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       serial_in,
   input  logic       start_bit_detected,
   input  logic       cnt_rollover,
   output logic       cnt_clear,
   output logic       cnt_enable,
   output logic [3:0] cnt_rollover_val,
   output logic       sample_strobe,
   output logic [2:0] bit_index,
   output logic       busy,
   output logic       packet_done,
   output logic       framing_error,
   output logic       parity_error
);

   localparam logic [3:0] HALF_V   = 4'(HALF_PERIOD);
   localparam logic [3:0] BIT_V    = 4'(BIT_PERIOD);
   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   state_t     state_q, state_d;
   logic       clr_q, clr_d;
   logic       en_q, en_d;
   logic [3:0] val_q, val_d;
   logic       strobe_q, strobe_d;
   logic [2:0] bi_q, bi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       fe_q, fe_d;
`ifdef PARITY_EN
   logic       pe_q, pe_d;
   logic       par_q, par_d;
`endif

   // Next-state and next-output logic; the rollover value only moves together with a clear.
   always_comb begin
      state_d  = state_q;
      clr_d    = clr_q;
      en_d     = en_q;
      val_d    = val_q;
      strobe_d = 1'b0;
      bi_d     = bi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      fe_d     = fe_q;
`ifdef PARITY_EN
      pe_d     = pe_q;
      par_d    = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            clr_d  = 1'b1;
            en_d   = 1'b0;
            val_d  = HALF_V;
            busy_d = 1'b0;
            if (start_bit_detected) begin
               state_d = S_START;
               clr_d   = 1'b0;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               fe_d    = 1'b0;
               bi_d    = 3'd0;
`ifdef PARITY_EN
               pe_d    = 1'b0;
               par_d   = 1'b0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_rollover) begin
               clr_d = 1'b1;
               if (!serial_in) begin
                  state_d = S_DATA;
                  val_d   = BIT_V;
               end else begin
                  state_d = S_IDLE;
                  en_d    = 1'b0;
                  busy_d  = 1'b0;
               end
            end else begin
               clr_d = 1'b0;
               en_d  = 1'b1;
            end
         end
         S_DATA: begin
            clr_d = 1'b0;
            en_d  = 1'b1;
            if (cnt_rollover) begin
               strobe_d = 1'b1;
`ifdef PARITY_EN
               par_d    = par_q ^ serial_in;
`endif
               if (bi_q == LAST_IDX) begin
`ifdef PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bi_d = bi_q + 3'd1;
               end
            end else begin
               strobe_d = 1'b0;
            end
         end
`ifdef PARITY_EN
         S_PARITY: begin
            if (cnt_rollover) begin
               state_d = S_STOP;
               pe_d    = (serial_in != par_q);
            end else begin
               state_d = S_PARITY;
            end
         end
`endif
         S_STOP: begin
            if (cnt_rollover) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
               en_d    = 1'b0;
               val_d   = HALF_V;
               busy_d  = 1'b0;
               if (serial_in) begin
`ifdef PARITY_EN
                  done_d = ~pe_q;
`else
                  done_d = 1'b1;
`endif
               end else begin
                  fe_d = 1'b1;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d = S_IDLE;
            clr_d   = 1'b1;
            en_d    = 1'b0;
            val_d   = HALF_V;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         clr_q    <= 1'b1;
         en_q     <= 1'b0;
         val_q    <= HALF_V;
         strobe_q <= 1'b0;
         bi_q     <= 3'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fe_q     <= 1'b0;
`ifdef PARITY_EN
         pe_q     <= 1'b0;
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         clr_q    <= clr_d;
         en_q     <= en_d;
         val_q    <= val_d;
         strobe_q <= strobe_d;
         bi_q     <= bi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fe_q     <= fe_d;
`ifdef PARITY_EN
         pe_q     <= pe_d;
         par_q    <= par_d;
`endif
      end
   end

   assign cnt_clear        = clr_q;
   assign cnt_enable       = en_q;
   assign cnt_rollover_val = val_q;
   assign sample_strobe    = strobe_q;
   assign bit_index        = bi_q;
   assign busy             = busy_q;
   assign packet_done      = done_q;
   assign framing_error    = fe_q;
`ifdef PARITY_EN
   assign parity_error     = pe_q;
`else
   assign parity_error     = 1'b0;
`endif

endmodule

// File: tb/tb_rx_timer_ctrl.sv
// Self-checking bench for rx_timer_ctrl: directed vector table, then frames run against a behavioural flex counter.
module tb_rx_timer_ctrl;
   localparam int BP = 10;
   localparam int DB = 8;
   localparam int HP = BP / 2;
`ifdef PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam logic [3:0] HV = 4'(HP);
   localparam logic [3:0] NV = 4'(BP);

   logic clk = 1'b0;
   logic n_rst, serial_in, start_bit_detected, cnt_rollover;
   logic cnt_clear, cnt_enable, sample_strobe, busy, packet_done, framing_error, parity_error;
   logic [3:0] cnt_rollover_val;
   logic [2:0] bit_index;
   logic tbl_mode, tbl_ro, cnt_flag;
   int cnt_v;
   int n_checks = 0;
   int n_fail = 0;
   logic exp_fe = 1'b0;
   logic exp_pe = 1'b0;
   logic [3:0] prev_val;

   typedef struct {
      logic sbd, ro, si;
      logic busy, clr, en;
      logic [3:0] val;
      logic strb;
      int bi;
      logic done, fe;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   rx_timer_ctrl #(.BIT_PERIOD(BP), .DATA_BITS(DB)) dut (
      .clk(clk), .n_rst(n_rst), .serial_in(serial_in),
      .start_bit_detected(start_bit_detected), .cnt_rollover(cnt_rollover),
      .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .cnt_rollover_val(cnt_rollover_val),
      .sample_strobe(sample_strobe), .bit_index(bit_index), .busy(busy),
      .packet_done(packet_done), .framing_error(framing_error), .parity_error(parity_error)
   );

   // Flex counter: counts 1..rollover_val, flag high while the count equals rollover_val.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_v <= 0; cnt_flag <= 1'b0;
      end else if (cnt_clear) begin
         cnt_v <= 0; cnt_flag <= 1'b0;
      end else if (cnt_enable) begin
         if (cnt_v == int'(cnt_rollover_val)) begin
            cnt_v <= 1; cnt_flag <= (int'(cnt_rollover_val) == 1);
         end else begin
            cnt_v <= cnt_v + 1; cnt_flag <= (cnt_v + 1 == int'(cnt_rollover_val));
         end
      end
   end
   assign cnt_rollover = tbl_mode ? tbl_ro : cnt_flag;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // The rollover value may only move in a cycle where the counter is being cleared.
   always @(negedge clk) begin
      if (n_rst === 1'b1 && prev_val !== cnt_rollover_val)
         check("val_change_without_clear", int'(cnt_clear), 1);
      prev_val <= cnt_rollover_val;
   end

   task automatic check_all(input string tag, input logic busy_e, input logic clr_e, input logic en_e,
                            input logic [3:0] val_e, input logic strb_e, input int bi_e,
                            input logic done_e, input logic fe_e, input logic pe_e);
      check({tag, ".busy"}, int'(busy), int'(busy_e));
      check({tag, ".clr"}, int'(cnt_clear), int'(clr_e));
      check({tag, ".en"}, int'(cnt_enable), int'(en_e));
      check({tag, ".val"}, int'(cnt_rollover_val), int'(val_e));
      check({tag, ".strobe"}, int'(sample_strobe), int'(strb_e));
      if (bi_e >= 0) check({tag, ".bit_index"}, int'(bit_index), bi_e);
      check({tag, ".done"}, int'(packet_done), int'(done_e));
      check({tag, ".ferr"}, int'(framing_error), int'(fe_e));
      check({tag, ".perr"}, int'(parity_error), int'(pe_e));
   endtask

   task automatic cyc(input logic sbd, input logic si, input logic ro);
      start_bit_detected = sbd; serial_in = si; tbl_ro = ro;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic void add(input logic sbd, input logic ro, input logic si, input logic b,
                               input logic c, input logic e, input logic [3:0] v, input logic s,
                               input int bi, input logic d, input logic f);
      vec_t r;
      r.sbd = sbd; r.ro = ro; r.si = si; r.busy = b; r.clr = c; r.en = e;
      r.val = v; r.strb = s; r.bi = bi; r.done = d; r.fe = f;
      tbl.push_back(r);
   endfunction

   // Ideal line level before edge rel (rel 0 = edge accepting the start); bits centred on expected samples.
   function automatic logic line_bit(input int rel, input logic [7:0] data, input logic stop_b,
                                     input logic par_b, input bit fs);
      int t, b;
      if (fs) return (rel <= 1) ? 1'b0 : 1'b1;
      t = rel - (HP + 3) + BP / 2;
      if (t < 0) return 1'b0;
      b = t / BP;
      if (b == 0) return 1'b0;
      if (b <= DB) return data[b - 1];
      if (PB == 1 && b == DB + 1) return par_b;
      if (b == DB + 1 + PB) return stop_b;
      return 1'b1;
   endfunction

   task automatic idle_gap(input int n);
      for (int g = 0; g < n; g++) begin
         cyc(1'b0, 1'b1, 1'b0);
         check_all("idle", 1'b0, 1'b1, 1'b0, HV, 1'b0, -1, 1'b0, exp_fe, exp_pe);
      end
   endtask

   // Strobe k lands at HP+3+k*BP: midpoint decision (HP+1) + k*BP + counter-clear and strobe-register latency.
   task automatic run_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok, input bit fs,
                            input int abort_k, input int noise);
      int first, rel_par, end_rel, nstr;
      logic par_b, sbd, strb_e, done_e, fe_e, pe_e, clr_e;
      logic [3:0] val_e;
      first   = HP + 3;
      rel_par = first + (DB + 1) * BP;
      end_rel = fs ? HP + 1 : first + (DB + PB + 1) * BP;
      par_b   = (^data) ^ !par_ok;
      for (int rel = 0; rel <= end_rel + 1; rel++) begin
         sbd = (rel == 0) || (rel <= end_rel && noise > 0 && $urandom_range(0, noise - 1) == 0);
         cyc(sbd, line_bit(rel, data, stop_ok, par_b, fs), 1'b0);
         nstr   = (!fs && rel >= first) ? (rel - first) / BP : 0;
         if (nstr > DB) nstr = DB;
         strb_e = !fs && rel >= first + BP && rel <= first + DB * BP && ((rel - first) % BP == 0);
         done_e = !fs && rel == end_rel && stop_ok && (PB == 0 || par_ok);
         fe_e   = !fs && rel >= end_rel && !stop_ok;
         pe_e   = PB == 1 && !fs && rel >= rel_par && !par_ok;
         clr_e  = (rel >= end_rel) || (!fs && rel == HP + 1);
         val_e  = (!fs && rel >= HP + 1 && rel < end_rel) ? NV : HV;
         check_all($sformatf("frame%02h.rel%0d", data, rel), rel < end_rel, clr_e, rel < end_rel,
                   val_e, strb_e, (rel >= end_rel) ? -1 : ((nstr < DB - 1) ? nstr : DB - 1),
                   done_e, fe_e, pe_e);
         if (abort_k > 0 && strb_e && nstr == abort_k) begin
            n_rst = 1'b0;
            #1;
            check_all("abort", 1'b0, 1'b1, 1'b0, HV, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            exp_fe = 1'b0; exp_pe = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n_rst = 1'b1;
            idle_gap(1);
            return;
         end
      end
      exp_fe = !fs && !stop_ok;
      exp_pe = PB == 1 && !fs && !par_ok;
   endtask

   initial begin
      logic par_t;
      n_rst = 1'b0; start_bit_detected = 1'b1; serial_in = 1'b0; tbl_ro = 1'b0; tbl_mode = 1'b1;
      // Reset held while a start pulse is present: reset wins.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset", 1'b0, 1'b1, 1'b0, HV, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      start_bit_detected = 1'b0; serial_in = 1'b1;
      n_rst = 1'b1;

      add(0,1,1, 0,1,0,HV,0,0,0,0);
      add(1,0,0, 1,0,1,HV,0,0,0,0);
      add(1,0,0, 1,0,1,HV,0,0,0,0);
      add(0,1,1, 0,1,0,HV,0,0,0,0);
      add(1,0,0, 1,0,1,HV,0,0,0,0);
      add(0,1,0, 1,1,1,NV,0,0,0,0);
      add(0,0,0, 1,0,1,NV,0,0,0,0);
      par_t = 1'b0;
      for (int k = 1; k <= DB; k++) begin
         add(0,1,1'(k & 1), 1,0,1,NV,1,(k < DB - 1) ? k : DB - 1,0,0);
         add(1,0,0, 1,0,1,NV,0,(k < DB - 1) ? k : DB - 1,0,0);
         par_t = par_t ^ 1'(k & 1);
      end
      if (PB == 1) add(0,1,par_t, 1,0,1,NV,0,DB - 1,0,0);
      add(0,1,0, 0,1,0,HV,0,-1,0,1);
      add(0,0,1, 0,1,0,HV,0,-1,0,1);
      add(1,0,0, 1,0,1,HV,0,0,0,0);
      add(0,1,1, 0,1,0,HV,0,0,0,0);
      add(0,0,1, 0,1,0,HV,0,0,0,0);
      foreach (tbl[i]) begin
         cyc(tbl[i].sbd, tbl[i].si, tbl[i].ro);
         check_all($sformatf("tbl[%0d]", i), tbl[i].busy, tbl[i].clr, tbl[i].en, tbl[i].val,
                   tbl[i].strb, tbl[i].bi, tbl[i].done, tbl[i].fe, 1'b0);
      end

      tbl_mode = 1'b0;
      idle_gap(2);
      run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0, 0); idle_gap(3);
      run_frame(8'h00, 1'b1, 1'b1, 1'b1, 0, 0); idle_gap(2);
      run_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0, 0); idle_gap(4);
      run_frame(8'h96, 1'b1, 1'b1, 1'b0, 3, 0); idle_gap(1);
      run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0, 0); idle_gap(2);
      run_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0, 4); idle_gap(2);
      run_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, 0); idle_gap(2);
      run_frame(8'h07, 1'b1, 1'b0, 1'b0, 0, 0); idle_gap(2);
      for (int f = 0; f < 24; f++) begin
         run_frame(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 5) == 0, 0, ($urandom_range(0, 1) == 1) ? 5 : 0);
         idle_gap(int'($urandom_range(1, 4)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rx_timer_ctrl.md
Name: rx_timer_ctrl

Overview:
Sequencing controller for the team's 4-bit flex counter when that counter is used as a bit-period timer in the serial receiver.
- Drives the counter's clear, count-enable and rollover value, and consumes its rollover flag.
- Walks a frame through start-bit midpoint check, data-bit sampling and stop-bit check.
- Emits one-cycle sample strobes for the shift register and frame-status pulses for the receiver FIFO.

Parameters:
BIT_PERIOD, 10, counter rollover value for one bit time; legal range 4..15
DATA_BITS, 8, data bits per frame; legal range 1..8
HALF_PERIOD, BIT_PERIOD/2 (integer), rollover value used to reach the start-bit midpoint

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
serial_in  in  1  synchronized receive line, idle high
start_bit_detected  in  1  one-cycle pulse from the edge detector
cnt_rollover  in  1  rollover_flag from the flex counter instance
cnt_clear  out  1  counter clear (registered)
cnt_enable  out  1  counter count_enable (registered)
cnt_rollover_val  out  4  counter rollover_val (registered)
sample_strobe  out  1  one-cycle pulse: shift serial_in into the data register
bit_index  out  3  index of the data bit currently being timed
busy  out  1  high in every state except IDLE
packet_done  out  1  one-cycle pulse: frame valid
framing_error  out  1  sticky: stop bit sampled low
parity_error  out  1  sticky parity mismatch; constant 0 when PARITY_EN is undefined

Behaviour:
- Interface: one clock, clk; reset n_rst is asynchronous and active-low. All outputs are registered.
- Reset values:
  - State IDLE.
  - cnt_clear=1, cnt_enable=0, cnt_rollover_val=HALF_PERIOD.
  - sample_strobe=0, bit_index=0, busy=0, packet_done=0.
  - framing_error=0, parity_error=0.
  - Reset mid-frame aborts the frame immediately, with no status pulse.
- Counter rule: cnt_rollover_val changes only in a cycle where cnt_clear=1. The counter therefore never sees a value change while counting.
- IDLE:
  - cnt_clear=1, cnt_enable=0.
  - On start_bit_detected: go to START_WAIT; clear framing_error and parity_error; bit_index=0; cnt_rollover_val=HALF_PERIOD.
- START_WAIT:
  - cnt_clear=0, cnt_enable=1.
  - On cnt_rollover with serial_in=0: go to DATA; pulse cnt_clear for one cycle; load cnt_rollover_val=BIT_PERIOD.
  - On cnt_rollover with serial_in=1: false start; return to IDLE with no error and no pulse.
- DATA:
  - cnt_enable=1 throughout; the counter free-runs and rolls over every BIT_PERIOD enabled cycles.
  - Each cnt_rollover produces a sample_strobe in the following cycle, and bit_index increments in that same cycle.
  - On the strobe for bit_index=DATA_BITS-1, go to STOP (or PARITY when enabled). bit_index saturates at DATA_BITS-1.
- STOP:
  - On cnt_rollover with serial_in=1: pulse packet_done in the next cycle.
  - On cnt_rollover with serial_in=0: set framing_error in the next cycle; no packet_done.
  - In both cases go to IDLE. In the IDLE entry cycle cnt_enable=0 and cnt_clear=1.
- start_bit_detected is ignored whenever busy=1.
- A cnt_rollover seen in IDLE is ignored.
- The sample point is the start-bit midpoint plus k*BIT_PERIOD clocks (k>=1); the bench checks this to +/-1 clock.
- If reset and start_bit_detected coincide, reset wins.

Optional Feature:
Macro PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, and bit_index holds during it.
  - A running XOR of serial_in is taken at each data strobe; it is cleared on entry to START_WAIT.
  - On the PARITY rollover: sample_strobe is NOT asserted. If serial_in differs from the XOR (even parity), parity_error is set, sticky until the next accepted start.
  - packet_done is suppressed if parity_error is set.
- Undefined: no PARITY state, parity_error tied 0, frame = start + DATA_BITS + stop.

Test Plan:
1. Reset, then frame 0xA5 LSB-first at BIT_PERIOD=10 with a valid stop bit:
   - exactly 8 sample_strobe pulses, spaced 10 clocks apart;
   - bit_index sequence 1..7 with the last held;
   - one packet_done; framing_error=0; busy falls after stop.
2. Glitch start: start_bit_detected, then serial_in returns high before the midpoint:
   - back to IDLE after HALF_PERIOD+1 clocks;
   - no strobe, no status pulse.
3. Stop bit held low on frame 0x3C:
   - 8 strobes, no packet_done, framing_error=1;
   - framing_error stays 1 until the next start_bit_detected, then clears.
4. n_rst asserted after the third data strobe:
   - all outputs return to reset values asynchronously;
   - a new frame 0xFF afterwards completes normally with one packet_done.
5. start_bit_detected pulsed during DATA and STOP:
   - ignored; strobe spacing unchanged;
   - cnt_rollover_val changes only in cycles with cnt_clear=1 (assertion).
6. PARITY_EN defined, frame 0x07:
   - parity bit 1 -> packet_done, parity_error=0;
   - parity bit 0 -> parity_error=1, no packet_done.
